// File: rtl/writeback_stage_if.sv
// Write-back stage bus: memory-stage inputs, W-register control, W contents,
// register-file write ports and status.
interface writeback_stage_if #(
  parameter int unsigned DW = 64
);
  logic [3:0]    m_stat;
  logic [3:0]    m_icode;
  logic [DW-1:0] m_valE;
  logic [DW-1:0] m_valM;
  logic [3:0]    m_dstE;
  logic [3:0]    m_dstM;
  logic          W_stall;
  logic          W_bubble;

  logic [3:0]    W_stat;
  logic [3:0]    W_icode;
  logic [DW-1:0] W_valE;
  logic [DW-1:0] W_valM;
  logic [3:0]    W_dstE;
  logic [3:0]    W_dstM;

  logic [3:0]    wb_dstE;
  logic [DW-1:0] wb_valE;
  logic [3:0]    wb_dstM;
  logic [DW-1:0] wb_valM;
  logic [3:0]    Stat;
  logic          halted;
  logic [31:0]   retire_cnt;

  modport master (
    output m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, W_stall, W_bubble,
    input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
    input  wb_dstE, wb_valE, wb_dstM, wb_valM, Stat, halted, retire_cnt
  );

  modport slave (
    input  m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, W_stall, W_bubble,
    output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
    output wb_dstE, wb_valE, wb_dstM, wb_valM, Stat, halted, retire_cnt
  );
endinterface

// File: rtl/writeback_stage.sv
// Y86-64 write-back stage: W pipeline register, register-file write ports,
// status and halt freeze. Optional retired-instruction counter: WB_RETIRE_CNT_EN.
module writeback_stage #(
  parameter int unsigned DW = 64
) (
  input  logic           clk,
  input  logic           rst,
  writeback_stage_if.slave bus
);
  localparam logic [3:0] RNONE     = 4'hF;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] STAT_BUB  = 4'd0;
  localparam logic [3:0] STAT_AOK  = 4'd1;
  localparam logic [3:0] STAT_HLT  = 4'd2;
  localparam logic [3:0] STAT_INS  = 4'd4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [3:0]    w_stat, w_icode, w_dste, w_dstm;
  logic [DW-1:0] w_vale, w_valm;
  logic [3:0]    w_stat_next, w_icode_next, w_dste_next, w_dstm_next;
  logic [DW-1:0] w_vale_next, w_valm_next;
  logic          w_exc;
  logic          w_commit;
  logic [3:0]    wb_dste_c, wb_dstm_c, stat_c;

  // HLT, ADR, INS and every unknown code (5-15) are exceptional
  assign w_exc    = (w_stat >= STAT_HLT);
  assign w_commit = (state == RUN) && (w_stat == STAT_AOK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next state and W register next value; a frozen machine holds W forever
  always_comb begin
    state_next   = state;
    w_stat_next  = w_stat;
    w_icode_next = w_icode;
    w_vale_next  = w_vale;
    w_valm_next  = w_valm;
    w_dste_next  = w_dste;
    w_dstm_next  = w_dstm;
    if ((state == RUN) && w_exc) state_next = HALTED;
    if ((state == HALTED) || w_exc || bus.W_stall) begin
      // hold
    end else if (bus.W_bubble) begin
      w_stat_next  = STAT_BUB;
      w_icode_next = ICODE_NOP;
      w_vale_next  = '0;
      w_valm_next  = '0;
      w_dste_next  = RNONE;
      w_dstm_next  = RNONE;
    end else begin
      w_stat_next  = bus.m_stat;
      w_icode_next = bus.m_icode;
      w_vale_next  = bus.m_valE;
      w_valm_next  = bus.m_valM;
      w_dste_next  = bus.m_dstE;
      w_dstm_next  = bus.m_dstM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_stat  <= STAT_BUB;
      w_icode <= ICODE_NOP;
      w_vale  <= '0;
      w_valm  <= '0;
      w_dste  <= RNONE;
      w_dstm  <= RNONE;
    end else begin
      w_stat  <= w_stat_next;
      w_icode <= w_icode_next;
      w_vale  <= w_vale_next;
      w_valm  <= w_valm_next;
      w_dste  <= w_dste_next;
      w_dstm  <= w_dstm_next;
    end
  end

  // Write-port gating; on a shared destination the M write wins (popq %rsp)
  always_comb begin
    wb_dste_c = RNONE;
    wb_dstm_c = RNONE;
    if (w_commit) begin
      wb_dstm_c = w_dstm;
      wb_dste_c = ((w_dste == w_dstm) && (w_dstm != RNONE)) ? RNONE : w_dste;
    end
  end

  always_comb begin
    stat_c = w_stat;
    if (w_stat == STAT_BUB)     stat_c = STAT_AOK;
    else if (w_stat > STAT_INS) stat_c = STAT_INS;
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_q;

  // Saturating count of AOK instructions leaving W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_q <= '0;
    else if (w_commit && !bus.W_stall && (retire_q != 32'hFFFF_FFFF))
      retire_q <= retire_q + 32'd1;
  end

  assign bus.retire_cnt = retire_q;
`else
  assign bus.retire_cnt = '0;
`endif

  assign bus.W_stat  = w_stat;
  assign bus.W_icode = w_icode;
  assign bus.W_valE  = w_vale;
  assign bus.W_valM  = w_valm;
  assign bus.W_dstE  = w_dste;
  assign bus.W_dstM  = w_dstm;
  assign bus.wb_dstE = wb_dste_c;
  assign bus.wb_dstM = wb_dstm_c;
  assign bus.wb_valE = w_vale;
  assign bus.wb_valM = w_valm;
  assign bus.Stat    = stat_c;
  assign bus.halted  = (state == HALTED);
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: scoreboard of expected write-port
// and status values plus a register-file model fed by the write ports.
module tb_writeback_stage;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [63:0] vale;
    logic [63:0] valm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t e;
  exp_t obs;
  logic [63:0] rf [16];
  logic [63:0] saved;

  always #5 clk = ~clk;

  writeback_stage_if #(.DW(64)) bus();
  writeback_stage #(.DW(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Register-file model: reset fills with index-tagged values
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 64'hA000_0000_0000_0000 | 64'(i);
    end else begin
      if (bus.wb_dstE != RNONE) rf[bus.wb_dstE] <= bus.wb_valE;
      if (bus.wb_dstM != RNONE) rf[bus.wb_dstM] <= bus.wb_valM;
    end
  end

  task automatic drive(input logic [3:0] st, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm);
    bus.m_stat  = st;
    bus.m_icode = ic;
    bus.m_valE  = ve;
    bus.m_valM  = vm;
    bus.m_dstE  = de;
    bus.m_dstM  = dm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.W_stall = 1'b0;
    bus.W_bubble = 1'b0;
    drive(4'd1, 4'd3, 64'h1, 64'h2, 4'd3, 4'd4);
    do_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.W_stat, bus.W_icode, bus.W_dstE, bus.W_dstM} !== 16'h01FF) begin
      n_fail++;
      $display("FAIL reset_w_ctrl: got %h want 01ff", {bus.W_stat, bus.W_icode, bus.W_dstE, bus.W_dstM});
    end
    n_checks++;
    if ({bus.W_valE, bus.W_valM} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_w_vals: got %h want 0", {bus.W_valE, bus.W_valM});
    end
    n_checks++;
    if ({bus.Stat, bus.halted} !== 5'b0001_0) begin
      n_fail++;
      $display("FAIL reset_status: Stat=%h halted=%b want 1/0", bus.Stat, bus.halted);
    end
    n_checks++;
    if ({bus.wb_dstE, bus.wb_dstM} !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_wb_dst: got %h want ff", {bus.wb_dstE, bus.wb_dstM});
    end
    n_checks++;
    if (bus.retire_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_retire: got %0d want 0", bus.retire_cnt);
    end
    drive(4'd0, 4'd1, 64'h0, 64'h0, RNONE, RNONE);
    step();
    rst = 1'b0;
  endtask

  task automatic test_normal_write();
    exp_t tbl [4];
    logic [3:0] ic [4];
    tbl[0] = '{4'd1, 4'd3, RNONE, 64'h2A,   64'h0};
    tbl[1] = '{4'd1, 4'd2, RNONE, 64'h1234, 64'h0};
    tbl[2] = '{4'd1, RNONE, 4'd6, 64'h40,   64'hBEEF};
    tbl[3] = '{4'd0, RNONE, RNONE, 64'h0,   64'h0};
    ic[0] = 4'd3; ic[1] = 4'd6; ic[2] = 4'd5; ic[3] = 4'd1;
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].stat, ic[i], tbl[i].vale, tbl[i].valm, tbl[i].dste, tbl[i].dstm);
      e = tbl[i];
      if (e.stat == 4'd0) e.stat = 4'd1;
      exp_q.push_back(e);
      step();
      e = exp_q.pop_front();
      obs = {bus.Stat, bus.wb_dstE, bus.wb_dstM, bus.wb_valE, bus.wb_valM};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL normal_wb[%0d]: got %h want %h", i, obs, e);
      end
    end
    n_checks++;
    if ({rf[3], rf[2], rf[6]} !== {64'h2A, 64'h1234, 64'hBEEF}) begin
      n_fail++;
      $display("FAIL normal_rf: rbx=%h rdx=%h rsi=%h want 2a/1234/beef", rf[3], rf[2], rf[6]);
    end
  endtask

  task automatic test_same_dest();
    drive(4'd1, 4'hB, 64'h100, 64'h55, 4'd4, 4'd4);
    exp_q.push_back('{4'd1, RNONE, 4'd4, 64'h100, 64'h55});
    step();
    drive(4'd0, 4'd1, 64'h0, 64'h0, RNONE, RNONE);
    exp_q.push_back('{4'd1, RNONE, RNONE, 64'h0, 64'h0});
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      obs = {bus.Stat, bus.wb_dstE, bus.wb_dstM, bus.wb_valE, bus.wb_valM};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL same_dest_wb[%0d]: got %h want %h", i, obs, e);
      end
      step();
    end
    n_checks++;
    if (rf[4] !== 64'h55) begin
      n_fail++;
      $display("FAIL same_dest_rsp: got %h want 55", rf[4]);
    end
  endtask

  task automatic test_stall_bubble();
    drive(4'd1, 4'd3, 64'h77, 64'h0, 4'd5, RNONE);
    step();
    bus.W_stall = 1'b1;
    bus.W_bubble = 1'b1;
    drive(4'd1, 4'd6, 64'h99, 64'h0, 4'd7, RNONE);
    step();
    step();
    n_checks++;
    if ({bus.W_stat, bus.W_icode, bus.W_dstE, bus.W_valE} !== {4'd1, 4'd3, 4'd5, 64'h77}) begin
      n_fail++;
      $display("FAIL stall_hold: stat=%h icode=%h dstE=%h valE=%h want 1/3/5/77",
               bus.W_stat, bus.W_icode, bus.W_dstE, bus.W_valE);
    end
    bus.W_stall = 1'b0;
    step();
    bus.W_bubble = 1'b0;
    n_checks++;
    if ({bus.W_stat, bus.W_icode, bus.Stat, bus.W_dstE, bus.wb_dstE} !== {4'd0, 4'd1, 4'd1, RNONE, RNONE}) begin
      n_fail++;
      $display("FAIL bubble_load: stat=%h icode=%h Stat=%h dstE=%h wb_dstE=%h want 0/1/1/f/f",
               bus.W_stat, bus.W_icode, bus.Stat, bus.W_dstE, bus.wb_dstE);
    end
  endtask

  task automatic test_counter();
    logic [3:0] st [9];
    int         stl [9];
    logic [31:0] want;
    st[0] = 4'd1; st[1] = 4'd1; st[2] = 4'd0; st[3] = 4'd1; st[4] = 4'd1;
    st[5] = 4'd0; st[6] = 4'd1; st[7] = 4'd0; st[8] = 4'd0;
    foreach (stl[i]) stl[i] = 0;
    stl[3] = 3;
`ifdef WB_RETIRE_CNT_EN
    want = 32'd5;
`else
    want = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(st[i], 4'd6, 64'(i), 64'h0, RNONE, RNONE);
      step();
      bus.W_stall = 1'b1;
      for (int k = 0; k < stl[i]; k++) step();
      bus.W_stall = 1'b0;
    end
    n_checks++;
    if (bus.retire_cnt !== want) begin
      n_fail++;
      $display("FAIL retire_count: got %0d want %0d", bus.retire_cnt, want);
    end
    // Asynchronous reset mid-stream, away from any clock edge
    drive(4'd1, 4'd3, 64'h5, 64'h0, 4'd3, RNONE);
    step();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.W_stat, bus.W_dstE, bus.Stat, bus.halted, bus.wb_dstE, bus.retire_cnt} !==
        {4'd0, RNONE, 4'd1, 1'b0, RNONE, 32'd0}) begin
      n_fail++;
      $display("FAIL async_reset: stat=%h dstE=%h Stat=%h halted=%b wb_dstE=%h cnt=%0d",
               bus.W_stat, bus.W_dstE, bus.Stat, bus.halted, bus.wb_dstE, bus.retire_cnt);
    end
    drive(4'd0, 4'd1, 64'h0, 64'h0, RNONE, RNONE);
    step();
    rst = 1'b0;
  endtask

  task automatic test_halt();
    saved = rf[0];
    drive(4'd2, 4'd0, 64'h123, 64'h0, 4'd0, RNONE);
    exp_q.push_back('{4'd2, RNONE, RNONE, 64'h123, 64'h0});
    step();
    e = exp_q.pop_front();
    obs = {bus.Stat, bus.wb_dstE, bus.wb_dstM, bus.wb_valE, bus.wb_valM};
    n_checks++;
    if (obs !== e || bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_entry: got %h halted=%b want %h halted=0", obs, bus.halted, e);
    end
    drive(4'd1, 4'd6, 64'h999, 64'h0, 4'd0, RNONE);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back('{4'd2, RNONE, RNONE, 64'h123, 64'h0});
      step();
      e = exp_q.pop_front();
      obs = {bus.Stat, bus.wb_dstE, bus.wb_dstM, bus.wb_valE, bus.wb_valM};
      n_checks++;
      if (obs !== e || bus.halted !== 1'b1 || bus.W_icode !== 4'd0 || rf[0] !== saved) begin
        n_fail++;
        $display("FAIL halt_frozen[%0d]: got %h halted=%b icode=%h rax=%h want %h halted=1 icode=0 rax=%h",
                 i, obs, bus.halted, bus.W_icode, rf[0], e, saved);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.halted, bus.Stat, bus.W_stat} !== {1'b0, 4'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL halt_reset: halted=%b Stat=%h W_stat=%h want 0/1/0", bus.halted, bus.Stat, bus.W_stat);
    end
    drive(4'd0, 4'd1, 64'h0, 64'h0, RNONE, RNONE);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_adr();
    saved = rf[1];
    drive(4'd3, 4'd5, 64'h10, 64'hBAD, RNONE, 4'd1);
    exp_q.push_back('{4'd3, RNONE, RNONE, 64'h10, 64'hBAD});
    step();
    e = exp_q.pop_front();
    obs = {bus.Stat, bus.wb_dstE, bus.wb_dstM, bus.wb_valE, bus.wb_valM};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL adr_wb: got %h want %h", obs, e);
    end
    drive(4'd0, 4'd1, 64'h0, 64'h0, RNONE, RNONE);
    step();
    step();
    n_checks++;
    if ({bus.halted, bus.Stat} !== {1'b1, 4'd3} || rf[1] !== saved) begin
      n_fail++;
      $display("FAIL adr_frozen: halted=%b Stat=%h rcx=%h want 1/3/%h", bus.halted, bus.Stat, rf[1], saved);
    end
  endtask

  initial begin
    test_reset();
    test_normal_write();
    test_same_dest();
    test_stall_bubble();
    test_counter();
    test_halt();
    test_adr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
